// File: rtl/br_checkpoint_stack.sv
// rtl/br_checkpoint_stack.sv - branch checkpoint storage with dependency-mask squash and 1-cycle recovery
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif

module br_checkpoint_stack #(
    parameter int BR_MASK_W  = 5,
    parameter int ARCH_REGS  = 32,
    parameter int PREG_IDX_W = 6,
    parameter int FL_PTR_W   = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            save_en_i,
    input  logic [BR_MASK_W-1:0]            save_bit_i,
    input  logic [BR_MASK_W-1:0]            save_dep_mask_i,
    input  logic [ARCH_REGS*PREG_IDX_W-1:0] mt_snapshot_i,
    input  logic [FL_PTR_W-1:0]             fl_head_i,
    input  logic [`BR_STATE_W-1:0]          br_state_i,
    input  logic [BR_MASK_W-1:0]            br_bit_i,
    output logic                            rcv_valid_o,
    output logic [ARCH_REGS*PREG_IDX_W-1:0] rcv_mt_o,
    output logic [FL_PTR_W-1:0]             rcv_fl_head_o,
    output logic [BR_MASK_W-1:0]            slot_valid_o,
    output logic                            err_o
);
    localparam int MT_W = ARCH_REGS * PREG_IDX_W;

    logic [BR_MASK_W-1:0] r_valid;
    logic [BR_MASK_W-1:0] r_dep [BR_MASK_W];
    logic [MT_W-1:0]      r_mt  [BR_MASK_W];
    logic [FL_PTR_W-1:0]  r_fl  [BR_MASK_W];
    logic                 r_rcv_valid;
    logic [MT_W-1:0]      r_rcv_mt;
    logic [FL_PTR_W-1:0]  r_rcv_fl;
    logic                 r_err;

    logic                 w_correct;
    logic                 w_wrong;
    logic                 w_res_ok;
    logic                 w_corr_act;
    logic                 w_wrong_act;
    logic                 w_save_ok;
    logic [BR_MASK_W-1:0] w_clr;
    logic [BR_MASK_W-1:0] w_save_vec;
    logic [BR_MASK_W-1:0] w_kill;
    logic [BR_MASK_W-1:0] w_valid_nxt;
    logic [MT_W-1:0]      w_sel_mt;
    logic [FL_PTR_W-1:0]  w_sel_fl;
    logic                 w_err_set;

    assign w_correct   = (br_state_i == `BR_PR_CORRECT);
    assign w_wrong     = (br_state_i == `BR_PR_WRONG);
    // A resolution only acts when it names exactly one live slot.
    assign w_res_ok    = $onehot(br_bit_i) && ((br_bit_i & r_valid) != '0);
    assign w_corr_act  = w_correct && w_res_ok;
    assign w_wrong_act = w_wrong && w_res_ok;
    assign w_clr       = w_corr_act ? br_bit_i : '0;
    assign w_save_ok   = save_en_i && !w_wrong && $onehot(save_bit_i);
    assign w_save_vec  = w_save_ok ? save_bit_i : '0;

    always_comb begin
        w_sel_mt = '0;
        w_sel_fl = '0;
        w_kill   = '0;
        for (int i = 0; i < BR_MASK_W; i++) begin
            if (br_bit_i[i]) begin
                w_sel_mt = w_sel_mt | r_mt[i];
                w_sel_fl = w_sel_fl | r_fl[i];
            end
            w_kill[i] = br_bit_i[i] | ((r_dep[i] & br_bit_i) != '0);
        end
    end

    // A save into a slot freed by a same-cycle CORRECT wins over the free.
    assign w_valid_nxt = (r_valid & ~w_clr & ~(w_wrong_act ? w_kill : '0)) | w_save_vec;

    assign w_err_set = (save_en_i && w_wrong)
                    || (save_en_i && !$onehot(save_bit_i))
                    || ((w_save_vec & r_valid & ~w_clr) != '0)
                    || ((w_correct || w_wrong) && !w_res_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid     <= '0;
            r_rcv_valid <= 1'b0;
            r_rcv_mt    <= '0;
            r_rcv_fl    <= '0;
            r_err       <= 1'b0;
            for (int i = 0; i < BR_MASK_W; i++) begin
                r_dep[i] <= '0;
            end
        end else begin
            r_valid     <= w_valid_nxt;
            r_rcv_valid <= w_wrong_act;
            if (w_wrong_act) begin
                r_rcv_mt <= w_sel_mt;
                r_rcv_fl <= w_sel_fl;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            for (int i = 0; i < BR_MASK_W; i++) begin
                r_dep[i] <= w_save_vec[i] ? (save_dep_mask_i & ~w_clr) : (r_dep[i] & ~w_clr);
            end
        end
    end

    // Snapshot payload is only meaningful while its valid bit is set, so it carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BR_MASK_W; i++) begin
            if (w_save_vec[i]) begin
                r_mt[i] <= mt_snapshot_i;
                r_fl[i] <= fl_head_i;
            end
        end
    end

    assign rcv_valid_o   = r_rcv_valid;
    assign rcv_mt_o      = r_rcv_mt;
    assign rcv_fl_head_o = r_rcv_fl;
    assign slot_valid_o  = r_valid;
    assign err_o         = r_err;
endmodule

// File: tb/tb_br_checkpoint_stack.sv
// tb/tb_br_checkpoint_stack.sv - directed self-checking bench for br_checkpoint_stack
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif

module tb_br_checkpoint_stack;
    localparam int MT_W = 192;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] COR  = `BR_PR_CORRECT;
    localparam logic [1:0] WRG  = `BR_PR_WRONG;

    logic            clk = 1'b0;
    logic            rst;
    logic            save_en_i;
    logic [4:0]      save_bit_i;
    logic [4:0]      save_dep_mask_i;
    logic [MT_W-1:0] mt_snapshot_i;
    logic [4:0]      fl_head_i;
    logic [1:0]      br_state_i;
    logic [4:0]      br_bit_i;
    logic            rcv_valid_o;
    logic [MT_W-1:0] rcv_mt_o;
    logic [4:0]      rcv_fl_head_o;
    logic [4:0]      slot_valid_o;
    logic            err_o;

    int total = 0;
    int bad = 0;

    br_checkpoint_stack dut (
        .clk(clk), .rst(rst),
        .save_en_i(save_en_i), .save_bit_i(save_bit_i), .save_dep_mask_i(save_dep_mask_i),
        .mt_snapshot_i(mt_snapshot_i), .fl_head_i(fl_head_i),
        .br_state_i(br_state_i), .br_bit_i(br_bit_i),
        .rcv_valid_o(rcv_valid_o), .rcv_mt_o(rcv_mt_o), .rcv_fl_head_o(rcv_fl_head_o),
        .slot_valid_o(slot_valid_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [MT_W-1:0] mk(input logic [31:0] k);
        return {6{k}};
    endfunction

    task automatic chk(input string tag, input logic [MT_W-1:0] obs, input logic [MT_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        save_en_i = 1'b0; save_bit_i = '0; save_dep_mask_i = '0;
        br_state_i = IDLE; br_bit_i = '0;
    endtask

    task automatic save(input logic [4:0] s, input logic [4:0] dep, input logic [31:0] k, input logic [4:0] fl);
        save_en_i = 1'b1; save_bit_i = s; save_dep_mask_i = dep;
        mt_snapshot_i = mk(k); fl_head_i = fl;
    endtask

    task automatic resolve(input logic [1:0] st, input logic [4:0] b);
        br_state_i = st; br_bit_i = b;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b0; tick(); tick(); rst = 1'b1;
    endtask

    initial begin
        mt_snapshot_i = '0; fl_head_i = '0;
        do_reset();
        chk("rst_slot", slot_valid_o, 0);
        chk("rst_rcv_valid", rcv_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rcv_mt", rcv_mt_o, 0);
        chk("rst_rcv_fl", rcv_fl_head_o, 0);

        // single save then wrong
        save(5'b00001, 5'b0, 32'hAAAA_0001, 5'd3); tick(); idle();
        chk("s0_slot", slot_valid_o, 5'b00001);
        resolve(WRG, 5'b00001); tick(); idle();
        chk("w0_rcv_valid", rcv_valid_o, 1);
        chk("w0_rcv_mt", rcv_mt_o, mk(32'hAAAA_0001));
        chk("w0_rcv_fl", rcv_fl_head_o, 3);
        chk("w0_slot", slot_valid_o, 0);
        tick();
        chk("w0_pulse_end", rcv_valid_o, 0);
        chk("w0_hold_mt", rcv_mt_o, mk(32'hAAAA_0001));
        chk("w0_err", err_o, 0);

        // chain squash: wrong on slot 1 kills 1 and 2
        save(5'b00001, 5'b00000, 32'hBBBB_0000, 5'd1); tick();
        save(5'b00010, 5'b00001, 32'hCCCC_0001, 5'd2); tick();
        save(5'b00100, 5'b00011, 32'hDDDD_0002, 5'd4); tick(); idle();
        chk("chain_slot", slot_valid_o, 5'b00111);
        resolve(WRG, 5'b00010); tick(); idle();
        chk("chain_rcv_valid", rcv_valid_o, 1);
        chk("chain_slot_after", slot_valid_o, 5'b00001);
        chk("chain_rcv_mt", rcv_mt_o, mk(32'hCCCC_0001));
        chk("chain_rcv_fl", rcv_fl_head_o, 2);

        // slot 0 live; add slot 1, correct 0, wrong 1
        save(5'b00010, 5'b00001, 32'hEEEE_0001, 5'd5); tick(); idle();
        chk("cw_slot", slot_valid_o, 5'b00011);
        resolve(COR, 5'b00001); tick(); idle();
        chk("cw_corr_slot", slot_valid_o, 5'b00010);
        chk("cw_corr_norcv", rcv_valid_o, 0);
        resolve(WRG, 5'b00010); tick(); idle();
        chk("cw_wrong_slot", slot_valid_o, 0);
        chk("cw_rcv_mt", rcv_mt_o, mk(32'hEEEE_0001));
        chk("cw_rcv_fl", rcv_fl_head_o, 5);

        // CORRECT must clear stale dep bits: slot 2 survives a later wrong on a reused slot 0
        save(5'b00001, 5'b00000, 32'h1111_0000, 5'd6); tick();
        save(5'b00100, 5'b00001, 32'h2222_0002, 5'd8); tick(); idle();
        resolve(COR, 5'b00001); tick(); idle();
        save(5'b00001, 5'b00000, 32'h3333_0000, 5'd9); tick(); idle();
        chk("dep_slot", slot_valid_o, 5'b00101);
        resolve(WRG, 5'b00001); tick(); idle();
        chk("dep_survive", slot_valid_o, 5'b00100);
        chk("dep_rcv_mt", rcv_mt_o, mk(32'h3333_0000));

        // CORRECT 0 and save into 0 in the same cycle
        save(5'b00001, 5'b00000, 32'h4444_0000, 5'd10); tick(); idle();
        save(5'b00001, 5'b00000, 32'h5555_0000, 5'd7); resolve(COR, 5'b00001); tick(); idle();
        chk("cs_slot", slot_valid_o, 5'b00101);
        chk("cs_err", err_o, 0);
        resolve(WRG, 5'b00001); tick(); idle();
        chk("cs_rcv_mt", rcv_mt_o, mk(32'h5555_0000));
        chk("cs_rcv_fl", rcv_fl_head_o, 7);
        chk("cs_slot_after", slot_valid_o, 5'b00100);
        resolve(WRG, 5'b00100); tick(); idle();
        chk("clear_slot", slot_valid_o, 0);
        chk("clear_rcv_mt", rcv_mt_o, mk(32'h2222_0002));

        // fill all five, then overflow
        for (int i = 0; i < 5; i++) begin
            save(5'(1 << i), 5'b00000, 32'h6000_0000 + i, 5'(i)); tick();
        end
        idle();
        chk("full_slot", slot_valid_o, 5'b11111);
        chk("full_err", err_o, 0);
        save(5'b00001, 5'b00000, 32'h7777_0000, 5'd0); tick(); idle();
        chk("ovf_err", err_o, 1);
        tick();
        chk("ovf_err_sticky", err_o, 1);

        // wrong on an empty slot after reset
        do_reset();
        chk("rst2_err", err_o, 0);
        chk("rst2_slot", slot_valid_o, 0);
        resolve(WRG, 5'b00001); tick(); idle();
        chk("empty_norcv", rcv_valid_o, 0);
        chk("empty_err", err_o, 1);
        chk("empty_rcv_mt", rcv_mt_o, 0);

        // non-one-hot CORRECT leaves state alone
        do_reset();
        save(5'b00001, 5'b00000, 32'h8888_0000, 5'd1); tick(); idle();
        resolve(COR, 5'b00011); tick(); idle();
        chk("noh_slot", slot_valid_o, 5'b00001);
        chk("noh_err", err_o, 1);

        // save during WRONG is dropped
        do_reset();
        save(5'b00001, 5'b00000, 32'h9999_0000, 5'd2); tick(); idle();
        save(5'b00010, 5'b00001, 32'hAAAA_0002, 5'd3); resolve(WRG, 5'b00001); tick(); idle();
        chk("sw_slot", slot_valid_o, 0);
        chk("sw_rcv_mt", rcv_mt_o, mk(32'h9999_0000));
        chk("sw_err", err_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
